inv_mix_col_iter: RTL

INV_MIX_COL_ITER -- requirements
Module: inv_mix_col_iter

---
 rtl/inv_mix_col_iter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/inv_mix_col_iter.sv
`timescale 1ns/1ps
// Purpose : AES InvMixColumns over a 128-bit state, one column per cycle on a shared column datapath.
// Latency : accept at edge E, result valid in the cycle after edge E+4 (bypass or not).
// Backpr. : single-entry; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data/in_bypass   - state in (byte k = bits [8k:8k+7], column c = bytes 4c..4c+3), bypass flag
//   in_valid/in_ready   - input handshake
//   out_data            - result state, same ordering
//   out_valid/out_ready - output handshake
module inv_mix_col_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] in_data,
  input  logic         in_bypass,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t       state_q;
  logic [1:0]   col_q;
  logic [0:127] work_q;
  logic [0:127] work_d;
  logic         byp_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [31:0]  col_in;
  logic [31:0]  col_mix;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column: r_i = sum_j coef[(j-i) mod 4] * a_j with coef = {0e,0b,0d,09}.
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Shared column datapath: select column col_q, transform, write back in place.
  always_comb begin
    col_in  = work_q[{col_q, 5'b0} +: 32];
    col_mix = inv_mix(col_in);
    work_d  = work_q;
    work_d[{col_q, 5'b0} +: 32] = byp_q ? col_in : col_mix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      byp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_data;
            byp_q      <= in_bypass;
            col_q      <= 2'd0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
          end
        end
        CALC: begin
          work_q <= work_d;
          if (col_q == 2'd3) begin
            // col stays at 3; it is only reset to 0 by the next capture.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean IDLE.
          state_q     <= IDLE;
          col_q       <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule
